serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 140 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder controller. An accepted start latches operands A and B and
// the initial carry. The controller then presents one bit pair per cycle,
// LSB first, to an external full-adder cell. It collects the returned sum bit
// into a result register and feeds the returned carry back in on the next
// cycle. After WIDTH bits it pulses done for one cycle. The final sum, carry
// out and signed overflow are held until the next accepted start.
//
// Ports
//   clk      in   1      clock, all state updates on the rising edge
//   rst      in   1      synchronous active-high reset, has priority over start
//   start    in   1      begin an addition (accepted only in IDLE)
//   a, b     in   WIDTH  operands
//   cin      in   1      initial carry-in
//   fa_a     out  1      A bit to the full-adder cell (0 outside RUN)
//   fa_b     out  1      B bit to the full-adder cell (0 outside RUN)
//   fa_rin   out  1      carry to the full-adder cell (0 outside RUN)
//   fa_s     in   1      sum bit from the full-adder cell (combinational)
//   fa_rout  in   1      carry-out from the full-adder cell
//   busy     out  1      high for the WIDTH cycles of RUN
//   done     out  1      one-cycle pulse, result valid
//   sum      out  WIDTH  A+B+cin mod 2^WIDTH (partial shift value during RUN)
//   cout     out  1      final carry-out
//   ovf      out  1      signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_rin,
  input  logic             fa_s,
  input  logic             fa_rout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               cout_q;
  logic               ovf_q;
  logic               accept;
  logic               last_bit;

  assign accept   = (state == S_IDLE) && start;
  assign last_bit = (state == S_RUN) && (cnt == LAST_BIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within a cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the operand/result registers are reset too, because after reset
  // sum must read zero and the full-adder pins must not carry stale bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_rout;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        // carry currently holds the carry into the MSB position.
        cout_q <= fa_rout;
        ovf_q  <= carry ^ fa_rout;
      end
    end
  end

  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_rin = 1'b0;
    if (state == S_RUN) begin
      fa_a   = a_sh[0];
      fa_b   = b_sh[0];
      fa_rin = carry;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign sum  = sum_sh;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Directed bench for serial_adder_ctrl at WIDTH=8 with a full-adder cell on
// the fa_* pins. Directed vectors carry hand-computed results. A bank of
// lockstep instances then covers all 2^17 (a,b,cin) combinations against an
// a+b+cin golden model.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W   = 8;
  localparam int NSW = 64;  // parallel instances for the exhaustive sweep

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         fa_a, fa_b, fa_rin, fa_s, fa_rout;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Full-adder cell
  assign fa_s    = fa_a ^ fa_b ^ fa_rin;
  assign fa_rout = (fa_a & fa_b) | (fa_rin & (fa_a ^ fa_b));

  serial_adder_ctrl #(.WIDTH(W)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_rin  (fa_rin),
    .fa_s    (fa_s),
    .fa_rout (fa_rout),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .ovf     (ovf)
  );

  // Sweep bank
  logic         sw_start;
  logic [W-1:0] sw_a    [NSW];
  logic [W-1:0] sw_b    [NSW];
  logic         sw_cin  [NSW];
  logic         sw_fa_a [NSW];
  logic         sw_fa_b [NSW];
  logic         sw_fa_r [NSW];
  logic         sw_busy [NSW];
  logic         sw_done [NSW];
  logic [W-1:0] sw_sum  [NSW];
  logic         sw_cout [NSW];
  logic         sw_ovf  [NSW];

  for (genvar k = 0; k < NSW; k++) begin : g_sw
    logic fs, fr;
    assign fs = sw_fa_a[k] ^ sw_fa_b[k] ^ sw_fa_r[k];
    assign fr = (sw_fa_a[k] & sw_fa_b[k]) | (sw_fa_r[k] & (sw_fa_a[k] ^ sw_fa_b[k]));

    serial_adder_ctrl #(.WIDTH(W)) u_sw (
      .clk     (clk),
      .rst     (rst),
      .start   (sw_start),
      .a       (sw_a[k]),
      .b       (sw_b[k]),
      .cin     (sw_cin[k]),
      .fa_a    (sw_fa_a[k]),
      .fa_b    (sw_fa_b[k]),
      .fa_rin  (sw_fa_r[k]),
      .fa_s    (fs),
      .fa_rout (fr),
      .busy    (sw_busy[k]),
      .done    (sw_done[k]),
      .sum     (sw_sum[k]),
      .cout    (sw_cout[k]),
      .ovf     (sw_ovf[k])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One edge, then settle 1 time unit past it for driving and sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accept edge; counts RUN cycles until busy drops.
  task automatic wait_done(output int n_busy);
    n_busy = 0;
    while (busy === 1'b1 && n_busy < 50) begin
      n_busy++;
      tick();
    end
  endtask

  task automatic run_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic [W-1:0] es, input logic ec,
                         input logic eo);
    int nb;
    a = ta; b = tb; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_first"}, 32'(busy), 32'd1);
    check({tag, "_fa_a_bit0"},  32'(fa_a), 32'(ta[0]));
    check({tag, "_fa_b_bit0"},  32'(fa_b), 32'(tb[0]));
    check({tag, "_fa_rin_bit0"}, 32'(fa_rin), 32'(tc));
    wait_done(nb);
    check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_sum"},  32'(sum),  32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"},  32'(ovf),  32'(eo));
    check({tag, "_fa_idle"}, 32'({fa_a, fa_b, fa_rin}), 32'd0);
    tick();
    check({tag, "_done_pulse_end"}, 32'({busy, done}), 32'd0);
    check({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int nb;
    int n_done;
    logic [16:0] idx;
    logic [8:0]  gold;
    logic        gold_ovf;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    sw_start = 1'b0;
    for (int k = 0; k < NSW; k++) begin
      sw_a[k] = '0; sw_b[k] = '0; sw_cin[k] = 1'b0;
    end
    tick();
    tick();
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_sum",       32'(sum), 32'd0);
    check("rst_cout_ovf",  32'({cout, ovf}), 32'd0);
    check("rst_fa",        32'({fa_a, fa_b, fa_rin}), 32'd0);
    rst = 1'b0;
    tick();

    run_add("add_03_05",    8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0);
    run_add("add_ff_01",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_add("add_7f_01",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_add("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start and operand changes during RUN are ignored
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    a = 8'hAA; b = 8'h55; cin = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wait_done(nb);
    check("ign_busy_cycles", 32'(nb + 2), 32'd8);
    check("ign_done", 32'(done), 32'd1);
    check("ign_sum",  32'(sum), 32'h30);
    check("ign_cout_ovf", 32'({cout, ovf}), 32'd0);
    tick();
    check("ign_no_second_run", 32'({busy, done}), 32'd0);

    // reset during RUN cycle 4
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy_done", 32'({busy, done}), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout_ovf", 32'({cout, ovf}), 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    run_add("after_rst_03_05", 8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0);

    // exhaustive sweep: combination idx -> {cin, b, a}
    for (int it = 0; it < (1 << 17) / NSW; it++) begin
      for (int k = 0; k < NSW; k++) begin
        idx = 17'(it * NSW + k);
        sw_a[k]   = idx[7:0];
        sw_b[k]   = idx[15:8];
        sw_cin[k] = idx[16];
      end
      sw_start = 1'b1;
      tick();
      sw_start = 1'b0;
      nb = 0;
      while (sw_done[0] !== 1'b1 && nb < 50) begin
        nb++;
        tick();
      end
      if (nb >= 50) begin
        check("sw_timeout", 32'(nb), 32'd8);
        break;
      end
      for (int k = 0; k < NSW; k++) begin
        gold     = 9'(sw_a[k]) + 9'(sw_b[k]) + 9'(sw_cin[k]);
        gold_ovf = (sw_a[k][7] == sw_b[k][7]) && (gold[7] != sw_a[k][7]);
        check("sw_done", 32'(sw_done[k]), 32'd1);
        check("sw_sum",  32'(sw_sum[k]),  32'(gold[7:0]));
        check("sw_cout", 32'(sw_cout[k]), 32'(gold[8]));
        check("sw_ovf",  32'(sw_ovf[k]),  32'(gold_ovf));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
